// File: rtl/adc_seq_pkg.sv
// rtl/adc_seq_pkg.sv - shared types and constants for the ADC capture sequencer
//
// Contents:
//   state_t    : sequencer states
//   rd_phase_t : per-word handshake phase inside READ_V / READ_I
//   CMD_ARM, CMD_READ, CMD_DONE : MCU command words
//   RD_WAIT    : cycles from strobe fall to rd_latch (RAM + output register)
package adc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_READY,
    ST_READ_V,
    ST_READ_I,
    ST_FINISH,
    ST_DONE_P
  } state_t;

  typedef enum logic [1:0] {
    PH_FALL,
    PH_WAIT,
    PH_RISE
  } rd_phase_t;

  localparam logic [15:0] CMD_ARM  = 16'h00AA;
  localparam logic [15:0] CMD_READ = 16'h00CC;
  localparam logic [15:0] CMD_DONE = 16'h00DD;

  localparam int RD_WAIT = 5;

endpackage

// File: rtl/adc_capture_seq_pulse_stretch.sv
// rtl/adc_capture_seq_pulse_stretch.sv - stretches a one-cycle trigger to LEN cycles
//
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   trig     : one-cycle request; pulse rises on the following clock edge
//   pulse    : high for exactly LEN cycles after trig (re-trigger restarts)
module pulse_stretch #(
  parameter int LEN = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic pulse
);

  localparam int CW = $clog2(LEN + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (trig) begin
      cnt <= CW'(LEN);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Decoded from the counter so a reset truncates the pulse at once.
  assign pulse = (cnt != '0);

endmodule

// File: rtl/adc_capture_seq.sv
// rtl/adc_capture_seq.sv - command sequencer for the dual-channel ADC capture buffer
//
// Optional feature macro: ADC_SEQ_WATCHDOG_EN (readout stall watchdog).
//
// Ports:
//   clk, rst    : sole clock, asynchronous active-high reset
//   cmd_data    : 16-bit MCU command word, qualified by cmd_valid
//   cmd_valid   : single-cycle command qualifier
//   rd_strobe   : asynchronous MCU read enable, idles high
//   save_over   : capture-complete level from the write side
//   cap_start   : PULSE_LEN-cycle capture-start pulse
//   rd_done     : PULSE_LEN-cycle read-finished pulse
//   rd_addr     : buffer read address
//   rd_sel      : 0 = voltage RAM, 1 = current RAM
//   rd_latch    : one-cycle pulse, datapath registers RAM dout on it
//   busy        : high whenever not IDLE
//   err_timeout : sticky watchdog flag (tied 0 without the watchdog)
module adc_capture_seq
  import adc_seq_pkg::*;
#(
  parameter int ADDR_W    = 11,
  parameter int PULSE_LEN = 200,
  parameter int TIMEOUT   = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       cmd_data,
  input  logic              cmd_valid,
  input  logic              rd_strobe,
  input  logic              save_over,
  output logic              cap_start,
  output logic              rd_done,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_sel,
  output logic              rd_latch,
  output logic              busy,
  output logic              err_timeout
);

  if (PULSE_LEN < 1 || TIMEOUT < 1) begin : g_param_check
    $error("adc_capture_seq: PULSE_LEN and TIMEOUT must be at least 1");
  end

  state_t    state, next_state;
  rd_phase_t phase;
  logic [2:0] wait_cnt;

  logic s_meta, s_sync, s_prev;
  logic fall, rise;
  logic cmd_arm, cmd_read, cmd_done;
  logic in_read, at_max;
  logic cap_trig, done_trig;
  logic wd_expire;

  // Strobe synchronizer plus edge-detect flop; all idle high so reset
  // release never manufactures a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_meta <= 1'b1;
      s_sync <= 1'b1;
      s_prev <= 1'b1;
    end else begin
      s_meta <= rd_strobe;
      s_sync <= s_meta;
      s_prev <= s_sync;
    end
  end

  assign fall = s_prev & ~s_sync;
  assign rise = ~s_prev & s_sync;

  assign cmd_arm  = cmd_valid && (cmd_data == CMD_ARM);
  assign cmd_read = cmd_valid && (cmd_data == CMD_READ);
  assign cmd_done = cmd_valid && (cmd_data == CMD_DONE);

  assign in_read = (state == ST_READ_V) || (state == ST_READ_I);
  assign at_max  = (rd_addr == {ADDR_W{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    cap_trig   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_arm) begin
          next_state = ST_CAPTURE;
          cap_trig   = 1'b1;
        end
      end
      ST_CAPTURE: begin
        // DONE outranks a simultaneous save_over.
        if (cmd_done)                     next_state = ST_DONE_P;
        else if (save_over && !cap_start) next_state = ST_READY;
      end
      ST_READY: begin
        if (cmd_done)      next_state = ST_DONE_P;
        else if (cmd_read) next_state = ST_READ_V;
      end
      ST_READ_V, ST_READ_I: begin
        if (cmd_done)       next_state = ST_DONE_P;
        else if (wd_expire) next_state = ST_IDLE;
        else if (phase == PH_RISE && rise && at_max)
          next_state = (state == ST_READ_V) ? ST_READ_I : ST_FINISH;
      end
      ST_FINISH: begin
        if (cmd_done) next_state = ST_DONE_P;
      end
      ST_DONE_P: begin
        if (!rd_done) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign done_trig = (next_state == ST_DONE_P) && (state != ST_DONE_P);
  assign busy      = (state != ST_IDLE);

  // Every state change restarts the address at 0; only entry to READ_I
  // selects the current RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= PH_FALL;
      wait_cnt <= '0;
      rd_addr  <= '0;
      rd_sel   <= 1'b0;
      rd_latch <= 1'b0;
    end else begin
      rd_latch <= 1'b0;
      if (state != next_state) begin
        phase    <= PH_FALL;
        wait_cnt <= '0;
        rd_addr  <= '0;
        rd_sel   <= (next_state == ST_READ_I);
      end else if (in_read) begin
        case (phase)
          PH_FALL: begin
            if (fall) begin
              phase    <= PH_WAIT;
              wait_cnt <= 3'(RD_WAIT);
            end
          end
          PH_WAIT: begin
            if (wait_cnt == 3'd1) begin
              rd_latch <= 1'b1;
              phase    <= PH_RISE;
            end else begin
              wait_cnt <= wait_cnt - 3'd1;
            end
          end
          PH_RISE: begin
            if (rise) begin
              rd_addr <= rd_addr + ADDR_W'(1);
              phase   <= PH_FALL;
            end
          end
          default: phase <= PH_FALL;
        endcase
      end
    end
  end

`ifdef ADC_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          wd_cnt <= '0;
    else if (!in_read || fall || rise) wd_cnt <= '0;
    else                              wd_cnt <= wd_cnt + WD_W'(1);
  end

  assign wd_expire = in_read && !fall && !rise && (wd_cnt == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            err_timeout <= 1'b0;
    else if (wd_expire) err_timeout <= 1'b1;
    else if (cap_trig)  err_timeout <= 1'b0;
  end
`else
  assign wd_expire   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  pulse_stretch #(.LEN(PULSE_LEN)) u_cap_start (
    .clk   (clk),
    .rst   (rst),
    .trig  (cap_trig),
    .pulse (cap_start)
  );

  pulse_stretch #(.LEN(PULSE_LEN)) u_rd_done (
    .clk   (clk),
    .rst   (rst),
    .trig  (done_trig),
    .pulse (rd_done)
  );

endmodule

// File: tb/tb_adc_capture_seq.sv
// tb/tb_adc_capture_seq.sv - directed self-checking bench for adc_capture_seq
module tb_adc_capture_seq;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   cmd_data;
  logic          cmd_valid;
  logic          rd_strobe;
  logic          save_over;
  logic          cap_start;
  logic          rd_done;
  logic [AW-1:0] rd_addr;
  logic          rd_sel;
  logic          rd_latch;
  logic          busy;
  logic          err_timeout;

  int n_checks = 0;
  int n_errors = 0;

  adc_capture_seq #(.ADDR_W(AW), .PULSE_LEN(4), .TIMEOUT(100)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_data    (cmd_data),
    .cmd_valid   (cmd_valid),
    .rd_strobe   (rd_strobe),
    .save_over   (save_over),
    .cap_start   (cap_start),
    .rd_done     (rd_done),
    .rd_addr     (rd_addr),
    .rd_sel      (rd_sel),
    .rd_latch    (rd_latch),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] c);
    cmd_data  = c;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_data  = 16'h0000;
  endtask

  function automatic logic [31:0] outs();
    return {22'd0, cap_start, rd_done, rd_latch, busy, err_timeout, rd_sel, rd_addr};
  endfunction

  // One strobe low/high cycle; reports ticks from pin fall to rd_latch
  // and the {rd_sel, rd_addr} seen alongside it.
  task automatic do_word(output int lat, output logic [31:0] seen);
    lat  = -1;
    seen = 32'hFFFF_FFFF;
    rd_strobe = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (rd_latch && lat < 0) begin
        lat  = k;
        seen = {27'd0, rd_sel, rd_addr};
      end
    end
    rd_strobe = 1'b1;
    repeat (4) tick();
  endtask

  task automatic arm_and_read();
    send(16'h00AA);
    repeat (10) tick();
    send(16'h00CC);
  endtask

  task automatic count_pulse(input string tag, input bit which_done);
    int n;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (which_done ? rd_done : cap_start) n++;
      tick();
    end
    check(tag, n, 4);
  endtask

  int          lat;
  logic [31:0] seen;
  int          seen_done;

  initial begin
    rst = 1'b1; cmd_data = 16'h0; cmd_valid = 1'b0; rd_strobe = 1'b1; save_over = 1'b0;
    repeat (3) tick();
    check("reset_outputs", outs(), 32'd0);
    rst = 1'b0;
    tick();

    send(16'h1234);
    check("idle_illegal", busy, 1'b0);
    send(16'h00CC);
    check("idle_read_ignored", busy, 1'b0);
    send(16'h00DD);
    check("idle_done_ignored", busy, 1'b0);

    // Full read
    save_over = 1'b1;
    send(16'h00AA);
    check("arm_busy", busy, 1'b1);
    count_pulse("cap_start_len", 1'b0);
    send(16'h1234);
    check("ready_illegal_busy", busy, 1'b1);
    send(16'h00CC);
    check("read_entry", {rd_sel, rd_addr}, 32'd0);

    // First word: strobe held low 20 cycles
    rd_strobe = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (rd_latch) begin
        if (lat < 0) lat = k;
        else lat = 99;
      end
    end
    check("latch_latency", lat, 8);
    check("held_low_addr", rd_addr, 0);
    rd_strobe = 1'b1;
    repeat (4) tick();
    check("addr_after_rise", rd_addr, 1);

    for (int w = 1; w < 32; w++) begin
      do_word(lat, seen);
      check($sformatf("word%0d_lat", w), lat, 8);
      check($sformatf("word%0d_addr", w), seen, (w < 16) ? w : (32'h10 | (w - 16)));
    end
    check("finish_state", {busy, rd_sel, rd_addr}, {1'b1, 5'd0});
    send(16'h00AA);
    check("finish_arm_ignored", {busy, cap_start}, 2'b10);
    send(16'h00DD);
    check("done_pulse_start", {rd_done, busy}, 2'b11);
    count_pulse("rd_done_len", 1'b1);
    check("full_read_idle", busy, 1'b0);

    // Abort after 3 words
    arm_and_read();
    for (int w = 0; w < 3; w++) do_word(lat, seen);
    check("abort_pre_addr", rd_addr, 3);
    send(16'h00DD);
    check("abort_state", {rd_done, busy, rd_sel, rd_addr}, {1'b1, 1'b1, 5'd0});
    repeat (10) tick();
    check("abort_idle", busy, 1'b0);
    send(16'h00CC);
    check("abort_read_ignored", busy, 1'b0);

    // ARM and junk inside READ_V
    arm_and_read();
    send(16'h00AA);
    check("readv_arm_ignored", {cap_start, busy}, 2'b01);
    send(16'h1234);
    do_word(lat, seen);
    check("readv_still_lat", lat, 8);
    check("readv_still_addr", seen, 0);
    send(16'h00DD);
    repeat (10) tick();

    // Stall in READ_V
    arm_and_read();
    seen_done = 0;
    for (int i = 0; i < 99; i++) begin
      tick();
      if (rd_done) seen_done++;
    end
    check("stall_99_busy", busy, 1'b1);
`ifdef ADC_SEQ_WATCHDOG_EN
    tick();
    check("wd_expire", {busy, err_timeout, rd_sel, rd_addr}, {1'b0, 1'b1, 5'd0});
    repeat (20) begin
      tick();
      if (rd_done) seen_done++;
    end
    check("wd_no_rd_done", seen_done, 0);
    check("wd_sticky", err_timeout, 1'b1);
    send(16'h00AA);
    check("wd_arm_clears", err_timeout, 1'b0);
    send(16'h00DD);
    repeat (10) tick();
`else
    repeat (60) tick();
    check("stall_holds", {busy, err_timeout}, 2'b10);
    do_word(lat, seen);
    check("stall_word_lat", lat, 8);
    send(16'h00DD);
    repeat (10) tick();
`endif

    // Reset mid cap_start
    send(16'h00AA);
    tick();
    check("mid_cap_high", cap_start, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_mid_cap", outs(), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Reset mid readout, while rd_latch is high
    arm_and_read();
    do_word(lat, seen);
    do_word(lat, seen);
    rd_strobe = 1'b0;
    repeat (8) tick();
    check("mid_read_latch", {rd_latch, rd_addr}, {1'b1, 4'd2});
    rst = 1'b1;
    #1;
    check("rst_mid_read", outs(), 32'd0);
    rd_strobe = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("post_reset_idle", outs(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
